// File: rtl/booth_mult_share_arbiter_pkg.sv
// ============================================================================
//  Module      : mult_arb_pkg
//  Description : Shared types and constants for the multiplier share arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arb_pkg;

    localparam int c_L_WORD_DEF = 8;
    localparam int c_N_REQ_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_share_arbiter_rr_pick_n.sv
// ============================================================================
//  Module      : rr_pick_n
//  Description : Combinational round-robin pick: first request at/after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick_n #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0] win_idx,
    output logic             any_req
);

    int w_pos;

    // Scan from farthest to nearest so the nearest hit overwrites the rest.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_req    = |req;
        w_pos      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = (int'(ptr) + k) % N_REQ;
            if (req[w_pos]) begin
                win_onehot        = '0;
                win_onehot[w_pos] = 1'b1;
                win_idx           = PTR_W'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/booth_mult_share_arbiter.sv
// ============================================================================
//  Module      : booth_mult_share_arbiter
//  Description : Round-robin sharing of one Start/Ready multiplier among
//                N_REQ clients. Watchdog enabled by `MULT_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int L_WORD      = c_L_WORD_DEF,
    parameter int N_REQ       = c_N_REQ_DEF,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*L_WORD-1:0] req_word1,
    input  logic [N_REQ*L_WORD-1:0] req_word2,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [2*L_WORD-1:0] rsp_product,
    output logic                busy,
    output logic                timeout_err,
    output logic [L_WORD-1:0]   mult_word1,
    output logic [L_WORD-1:0]   mult_word2,
    output logic                mult_start,
    input  logic [2*L_WORD-1:0] mult_product,
    input  logic                mult_ready
);

    localparam int               c_PTR_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] c_ONE   = N_REQ'(1);

    arb_state_t          r_state, w_state_nxt;
    logic [c_PTR_W-1:0]  r_ptr, r_owner;
    logic [N_REQ-1:0]    w_win_oh;
    logic [c_PTR_W-1:0]  w_win_idx;
    logic                w_any_req;
    logic [N_REQ-1:0]    r_gnt, r_rsp_valid;
    logic [2*L_WORD-1:0] r_rsp_product;
    logic [L_WORD-1:0]   r_word1, r_word2;
    logic                w_in_wait, w_done, w_abort;

    rr_pick_n #(
        .N_REQ (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_pick (
        .req        (req),
        .ptr        (r_ptr),
        .win_onehot (w_win_oh),
        .win_idx    (w_win_idx),
        .any_req    (w_any_req)
    );

    assign w_in_wait = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    assign w_done    = (r_state == WAIT_DONE) && mult_ready;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int c_CNT_W = clog2(TIMEOUT_CYC + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout_err;

    // Abort on the TIMEOUT_CYC-th waiting cycle; a real completion wins a tie.
    assign w_abort = w_in_wait && !w_done && (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_abort;
            if (r_state == START) begin
                r_cnt <= '0;
            end else if (w_in_wait) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYC;
    assign w_abort          = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:      if (w_any_req) w_state_nxt = START;
            START:     w_state_nxt = WAIT_BUSY;
            // Ready is also high while the multiplier is idle, so wait for it to drop first.
            WAIT_BUSY: begin
                if (w_abort)          w_state_nxt = IDLE;
                else if (!mult_ready) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (w_done || w_abort) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_owner       <= '0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_rsp_product <= '0;
            r_word1       <= '0;
            r_word2       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            if ((r_state == IDLE) && w_any_req) begin
                r_gnt   <= w_win_oh;
                r_owner <= w_win_idx;
                r_word1 <= req_word1[int'(w_win_idx)*L_WORD +: L_WORD];
                r_word2 <= req_word2[int'(w_win_idx)*L_WORD +: L_WORD];
                r_ptr   <= (w_win_idx == c_PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + c_PTR_W'(1);
            end
            if (w_done) begin
                r_rsp_product <= mult_product;
                r_rsp_valid   <= c_ONE << r_owner;
            end else if (w_abort) begin
                r_rsp_product <= '0;
                r_rsp_valid   <= c_ONE << r_owner;
            end
        end
    end

    assign gnt         = r_gnt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_rsp_product;
    assign busy        = (r_state != IDLE);
    assign mult_word1  = r_word1;
    assign mult_word2  = r_word2;
    assign mult_start  = (r_state == START);

endmodule

`default_nettype wire
